// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes, FSM states,
// access sizes and the writeback reset constants.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LW   = 4'd3,
    MEMOP_LBU  = 4'd4,
    MEMOP_LHU  = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering for the LSU: op decode, alignment check, byte enables,
// store-data replication and load byte/half extraction with sign/zero extension.
module mem_align
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        mem_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] sdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_mem,
  output logic              is_store,
  output logic              misalign,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  mem_size_e   size;
  logic        is_signed;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Undefined op codes fall into the default arm and behave as NONE.
  always_comb begin
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (mem_op)
      MEMOP_LB:  begin is_mem = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
      MEMOP_LH:  begin is_mem = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
      MEMOP_LW:  begin is_mem = 1'b1; size = SZ_WORD; end
      MEMOP_LBU: begin is_mem = 1'b1; size = SZ_BYTE; end
      MEMOP_LHU: begin is_mem = 1'b1; size = SZ_HALF; end
      MEMOP_SB:  begin is_mem = 1'b1; is_store = 1'b1; size = SZ_BYTE; end
      MEMOP_SH:  begin is_mem = 1'b1; is_store = 1'b1; size = SZ_HALF; end
      MEMOP_SW:  begin is_mem = 1'b1; is_store = 1'b1; size = SZ_WORD; end
      default:   ;
    endcase
  end

  assign misalign = is_mem && (((size == SZ_HALF) && addr_lo[0]) ||
                               ((size == SZ_WORD) && (addr_lo != 2'b00)));

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata     = sdata;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{sdata[7:0]}};
        load_data = {{(DATA_W-8){is_signed & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{sdata[15:0]}};
        load_data = {{(DATA_W-16){is_signed & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes non-memory writeback through, and runs a req/ack
// bus transaction for loads/stores with pipeline stall, timeout and misalign reporting.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [DATA_W-1:0] reg_wdata_in,
  input  logic [REG_AW-1:0] reg_waddr_in,
  input  logic              reg_we_in,
  input  logic [3:0]        mem_op_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_sdata_in,
  output logic              data_req_out,
  output logic              data_we_out,
  output logic [ADDR_W-1:0] data_addr_out,
  output logic [3:0]        data_be_out,
  output logic [DATA_W-1:0] data_wdata_out,
  input  logic              data_ack_in,
  input  logic [DATA_W-1:0] data_rdata_in,
  output logic              stall_req_out,
  output logic              misalign_out,
  output logic              bus_err_out,
  output logic [DATA_W-1:0] reg_wdata_out,
  output logic [REG_AW-1:0] reg_waddr_out,
  output logic              reg_we_out
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic              is_mem, is_store, misalign;
  logic [3:0]        be;
  logic [DATA_W-1:0] bus_wdata, load_data;

  lsu_state_e        state_q, state_d;
  logic [7:0]        cnt_q;

  logic              req, stall, misal_p, berr, we_o;
  logic [DATA_W-1:0] wdata_o;
  logic              bus_on;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .mem_op    (mem_op_in),
    .addr_lo   (mem_addr_in[1:0]),
    .sdata     (mem_sdata_in),
    .rdata     (data_rdata_in),
    .is_mem    (is_mem),
    .is_store  (is_store),
    .misalign  (misalign),
    .be        (be),
    .wdata     (bus_wdata),
    .load_data (load_data)
  );

  // Counter is held at zero outside WAIT, so it always restarts from 0 on entry.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_WAIT) ? cnt_q + 8'd1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    misal_p = 1'b0;
    berr    = 1'b0;
    we_o    = reg_we_in;
    wdata_o = reg_wdata_in;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          if (misalign) begin
            misal_p = 1'b1;
            we_o    = WRITE_DISABLE;
          end else begin
            req = 1'b1;
            if (data_ack_in) begin
              we_o    = is_store ? WRITE_DISABLE : reg_we_in;
              wdata_o = is_store ? reg_wdata_in : load_data;
            end else begin
              stall   = 1'b1;
              we_o    = WRITE_DISABLE;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (data_ack_in) begin
          req     = 1'b1;
          we_o    = is_store ? WRITE_DISABLE : reg_we_in;
          wdata_o = is_store ? reg_wdata_in : load_data;
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          berr    = 1'b1;
          we_o    = WRITE_DISABLE;
          state_d = ST_IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          we_o  = WRITE_DISABLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is gated by reset so a mid-transaction reset drops the bus at once.
  assign bus_on         = reset_n_in & req;
  assign data_req_out   = bus_on;
  assign data_we_out    = bus_on & is_store;
  assign data_addr_out  = bus_on ? {mem_addr_in[ADDR_W-1:2], 2'b00} : '0;
  assign data_be_out    = bus_on ? be : '0;
  assign data_wdata_out = bus_on ? bus_wdata : '0;
  assign stall_req_out  = reset_n_in & stall;
  assign misalign_out   = reset_n_in & misal_p;
  assign bus_err_out    = reset_n_in & berr;
  assign reg_wdata_out  = reset_n_in ? wdata_o : '0;
  assign reg_waddr_out  = reset_n_in ? reg_waddr_in : '0;
  assign reg_we_out     = reset_n_in ? we_o : WRITE_DISABLE;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand-written reset sequence, and random
// transactions checked against an arithmetic reference model.
module tb_mem_lsu;

  localparam int unsigned TMO = 4;
  localparam int K_PASS = 0, K_MIS = 1, K_OK = 2, K_TO = 3;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [31:0] reg_wdata_in;
  logic [4:0]  reg_waddr_in;
  logic        reg_we_in;
  logic [3:0]  mem_op_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_sdata_in;
  logic        data_req_out, data_we_out;
  logic [31:0] data_addr_out;
  logic [3:0]  data_be_out;
  logic [31:0] data_wdata_out;
  logic        data_ack_in;
  logic [31:0] data_rdata_in;
  logic        stall_req_out, misalign_out, bus_err_out;
  logic [31:0] reg_wdata_out;
  logic [4:0]  reg_waddr_out;
  logic        reg_we_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT(TMO)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .reg_wdata_in   (reg_wdata_in),
    .reg_waddr_in   (reg_waddr_in),
    .reg_we_in      (reg_we_in),
    .mem_op_in      (mem_op_in),
    .mem_addr_in    (mem_addr_in),
    .mem_sdata_in   (mem_sdata_in),
    .data_req_out   (data_req_out),
    .data_we_out    (data_we_out),
    .data_addr_out  (data_addr_out),
    .data_be_out    (data_be_out),
    .data_wdata_out (data_wdata_out),
    .data_ack_in    (data_ack_in),
    .data_rdata_in  (data_rdata_in),
    .stall_req_out  (stall_req_out),
    .misalign_out   (misalign_out),
    .bus_err_out    (bus_err_out),
    .reg_wdata_out  (reg_wdata_out),
    .reg_waddr_out  (reg_waddr_out),
    .reg_we_out     (reg_we_out)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        bwe;
    logic [31:0] rwdata;
    logic        rwe;
    logic        chk_rw;
    logic [7:0]  ncyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata, wd;
    logic [4:0]  wa;
    logic        we;
    int          delay;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: size in bytes from the op, lanes and extension from plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic [31:0] wd, input logic we, input int delay);
    exp_t e;
    int unsigned nb, off;
    logic [31:0] v, mask;
    e = '0;
    case (op)
      4'd1, 4'd4, 4'd6: nb = 1;
      4'd2, 4'd5, 4'd7: nb = 2;
      4'd3, 4'd8:       nb = 4;
      default:          nb = 0;
    endcase
    if (nb == 0) begin
      e.kind = 2'(K_PASS); e.rwdata = wd; e.rwe = we; e.chk_rw = 1'b1; e.ncyc = 8'd1;
      return e;
    end
    off = addr % 4;
    if ((addr % nb) != 0) begin
      e.kind = 2'(K_MIS); e.ncyc = 8'd1;
      return e;
    end
    e.be  = 4'(((1 << nb) - 1) << off);
    e.bwe = (op >= 4'd6);
    for (int unsigned i = 0; i < 4; i++)
      e.bwdata[8*i +: 8] = sdata[8*(i % nb) +: 8];
    if (!e.bwe) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      v = (rdata >> (8*off)) & mask;
      if ((op == 4'd1 || op == 4'd2) && v[8*nb-1]) v = v | ~mask;
      e.rwdata = v; e.rwe = we; e.chk_rw = 1'b1;
    end
    if (delay < 0 || delay > int'(TMO) + 1) begin
      e.kind = 2'(K_TO); e.ncyc = 8'(TMO + 2); e.rwe = 1'b0; e.chk_rw = 1'b0;
    end else begin
      e.kind = 2'(K_OK); e.ncyc = 8'(delay + 1);
    end
    return e;
  endfunction

  // Entered and left at posedge+1; drives one transaction and checks every cycle.
  task automatic run_txn(input vec_t v);
    int   kind;
    logic fin, exp_req;
    kind = int'(v.e.kind);
    for (int k = 0; k < int'(v.e.ncyc); k++) begin
      fin = (k == int'(v.e.ncyc) - 1);
      mem_op_in     = v.op;
      mem_addr_in   = v.addr;
      mem_sdata_in  = v.sdata;
      reg_wdata_in  = v.wd;
      reg_waddr_in  = v.wa;
      reg_we_in     = v.we;
      data_ack_in   = (kind == K_OK) && (k == v.delay);
      data_rdata_in = data_ack_in ? v.rdata : $urandom;
      #2;
      exp_req = (kind == K_OK) || (kind == K_TO && !fin);
      chk({v.name, ".req"},   32'(data_req_out),  32'(exp_req));
      chk({v.name, ".stall"}, 32'(stall_req_out), 32'((kind == K_OK || kind == K_TO) && !fin));
      chk({v.name, ".mis"},   32'(misalign_out),  32'(kind == K_MIS));
      chk({v.name, ".berr"},  32'(bus_err_out),   32'(kind == K_TO && fin));
      chk({v.name, ".waddr"}, 32'(reg_waddr_out), 32'(v.wa));
      if (kind == K_PASS)
        chk({v.name, ".we"}, 32'(reg_we_out), 32'(v.e.rwe));
      else if (kind == K_OK && fin)
        chk({v.name, ".we"}, 32'(reg_we_out), 32'(v.e.rwe));
      else
        chk({v.name, ".we"}, 32'(reg_we_out), 32'(0));
      if (v.e.chk_rw && (kind == K_PASS || fin))
        chk({v.name, ".rwdata"}, reg_wdata_out, v.e.rwdata);
      if (exp_req) begin
        chk({v.name, ".addr"}, data_addr_out, {v.addr[31:2], 2'b00});
        chk({v.name, ".be"},   32'(data_be_out), 32'(v.e.be));
        chk({v.name, ".bwe"},  32'(data_we_out), 32'(v.e.bwe));
        if (v.e.bwe) chk({v.name, ".bwdata"}, data_wdata_out, v.e.bwdata);
      end
      @(posedge clk_in); #1;
    end
    data_ack_in = 1'b0;
  endtask

  function automatic vec_t mkv(input string name, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic [31:0] wd, input logic [4:0] wa, input logic we,
                               input int delay, input int kind, input logic [3:0] be,
                               input logic [31:0] bwdata, input logic bwe,
                               input logic [31:0] rwdata, input logic rwe,
                               input logic chk_rw, input int ncyc);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.wd = wd; v.wa = wa; v.we = we; v.delay = delay;
    v.e.kind = 2'(kind); v.e.be = be; v.e.bwdata = bwdata; v.e.bwe = bwe;
    v.e.rwdata = rwdata; v.e.rwe = rwe; v.e.chk_rw = chk_rw; v.e.ncyc = 8'(ncyc);
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    tbl.push_back(mkv("none",    4'd0, 32'h0,    32'h0,        32'h0,        32'h1234, 5'd5, 1'b1, -1, K_PASS, 4'h0, 32'h0,        1'b0, 32'h1234,     1'b1, 1'b1, 1));
    tbl.push_back(mkv("lb",      4'd1, 32'h1003, 32'h0,        32'h80FFFFFF, 32'h0,    5'd3, 1'b1,  2, K_OK,   4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, 1'b1, 3));
    tbl.push_back(mkv("sh",      4'd7, 32'h2002, 32'hABCD1234, 32'h0,        32'h0,    5'd4, 1'b1,  0, K_OK,   4'hC, 32'h12341234, 1'b1, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mkv("lw_mis",  4'd3, 32'h3001, 32'h0,        32'h0,        32'h0,    5'd6, 1'b1, -1, K_MIS,  4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mkv("lhu",     4'd5, 32'h3002, 32'h0,        32'h8001BEEF, 32'h0,    5'd7, 1'b1,  1, K_OK,   4'hC, 32'h0,        1'b0, 32'h00008001, 1'b1, 1'b1, 2));
    tbl.push_back(mkv("lw_tmo",  4'd3, 32'h4000, 32'h0,        32'h0,        32'h0,    5'd8, 1'b1, -1, K_TO,   4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, TMO + 2));
    tbl.push_back(mkv("sb",      4'd6, 32'h5001, 32'h000000A5, 32'h0,        32'h0,    5'd9, 1'b1,  1, K_OK,   4'h2, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 2));
    tbl.push_back(mkv("lh_last", 4'd2, 32'h6002, 32'h0,        32'h87650000, 32'h0,    5'd10, 1'b1, TMO + 1, K_OK, 4'hC, 32'h0,   1'b0, 32'hFFFF8765, 1'b1, 1'b1, TMO + 2));
    tbl.push_back(mkv("undef",   4'hF, 32'h7003, 32'h0,        32'h0,        32'hCAFE, 5'd11, 1'b1, -1, K_PASS, 4'h0, 32'h0,       1'b0, 32'hCAFE,     1'b1, 1'b1, 1));
    tbl.push_back(mkv("sw",      4'd8, 32'h8004, 32'h11223344, 32'h0,        32'h0,    5'd12, 1'b1, 3, K_OK,   4'hF, 32'h11223344, 1'b1, 32'h0,        1'b0, 1'b0, 4));
    tbl.push_back(mkv("lbu",     4'd4, 32'h9002, 32'h0,        32'h00F00000, 32'h0,    5'd13, 1'b1, 0, K_OK,   4'h4, 32'h0,        1'b0, 32'h000000F0, 1'b1, 1'b1, 1));
    tbl.push_back(mkv("sw_mis",  4'd8, 32'h8006, 32'h0,        32'h0,        32'h0,    5'd14, 1'b1, -1, K_MIS, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1));

    reset_n_in = 1'b0; mem_op_in = 4'd0; mem_addr_in = '0; mem_sdata_in = '0;
    reg_wdata_in = 32'h5555; reg_waddr_in = 5'd3; reg_we_in = 1'b1;
    data_ack_in = 1'b0; data_rdata_in = '0;
    #2;
    chk("rst.we",    32'(reg_we_out),    32'(0));
    chk("rst.wdata", reg_wdata_out,      32'(0));
    chk("rst.waddr", 32'(reg_waddr_out), 32'(0));
    chk("rst.req",   32'(data_req_out),  32'(0));
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset during WAIT: bus and writeback fall at once; afterwards a fresh timeout.
    mem_op_in = 4'd3; mem_addr_in = 32'h7000; reg_we_in = 1'b1; reg_waddr_in = 5'd2;
    data_ack_in = 1'b0;
    #2;
    chk("rw.stall0", 32'(stall_req_out), 32'(1));
    @(posedge clk_in); #1;
    @(posedge clk_in); #2;
    chk("rw.stall2", 32'(stall_req_out), 32'(1));
    reset_n_in = 1'b0;
    #1;
    chk("rw.req",   32'(data_req_out),  32'(0));
    chk("rw.stall", 32'(stall_req_out), 32'(0));
    chk("rw.be",    32'(data_be_out),   32'(0));
    chk("rw.we",    32'(reg_we_out),    32'(0));
    chk("rw.berr",  32'(bus_err_out),   32'(0));
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    rv = mkv("post_rst", 4'd3, 32'h7000, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, -1,
             K_TO, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, TMO + 2);
    run_txn(rv);
    rv = mkv("post_lw", 4'd3, 32'h7004, 32'h0, 32'h13579BDF, 32'h0, 5'd2, 1'b1, 1,
             K_OK, 4'hF, 32'h0, 1'b0, 32'h13579BDF, 1'b1, 1'b1, 2);
    run_txn(rv);

    for (int n = 0; n < 300; n++) begin
      rv.name  = "rand";
      rv.op    = 4'($urandom_range(0, 15));
      rv.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.wd    = $urandom;
      rv.wa    = 5'($urandom);
      rv.we    = 1'($urandom);
      rv.delay = int'($urandom_range(0, TMO + 3));
      rv.e     = model(rv.op, rv.addr, rv.sdata, rv.rdata, rv.wd, rv.we, rv.delay);
      run_txn(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
